// File: rtl/audio_tone_sequencer.sv
// Audio tone sequencer: plays entries of a writable note table as a square wave with a duty hint.
// Define AUDIO_TONE_DECAY_EN to make the duty hint decay by one step per tick during each note.
module audio_tone_sequencer #(
  parameter int SYSTEM_FREQ = 100000000,
  parameter int TICK_CYCLES = 100000,
  parameter int DEPTH       = 16,
  parameter int HALF_W      = 20,
  parameter int DUR_W       = 12,
  parameter int GAP_TICKS   = 10,
  parameter int DUTY_ON     = 100,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [HALF_W-1:0] wr_half,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic              start,
  input  logic [AW:0]       len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              tone_out,
  output logic [6:0]        duty_cycle,
  output logic              audio_en
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int NW = (DUR_W > GW) ? DUR_W : GW;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [NW-1:0] GAP_LAST  = NW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit            GAP_ZERO  = (GAP_TICKS == 0);
  localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [6:0]    DUTY_VAL  = 7'(DUTY_ON);
  localparam logic [AW-1:0] IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     idx_r;
  logic [AW:0]       len_r;
  logic [HALF_W-1:0] cur_half_r;
  logic [NW-1:0]     cur_last_r;
  logic [HALF_W-1:0] half_cnt_r;
  logic [TW-1:0]     tick_cnt_r;
  logic [NW-1:0]     tick_num_r;
  logic              busy_r;
  logic              done_r;
  logic              tone_r;
  logic [6:0]        duty_r;

  logic [HALF_W-1:0] half_mem_r [DEPTH];
  logic [DUR_W-1:0]  dur_mem_r  [DEPTH];

  logic              half_wrap_s;
  logic              tick_wrap_s;
  logic              play_end_s;
  logic              gap_end_s;
  logic              tone_nxt_s;
  logic              last_note_s;
  logic [DUR_W-1:0]  ld_dur_s;
  logic [NW-1:0]     ld_last_s;
  logic [AW:0]       len_clamp_s;
  logic [6:0]        level_s;

  // Note table: written only while idle; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && (state_r == IDLE)) begin
      half_mem_r[wr_addr] <= wr_half;
      dur_mem_r[wr_addr]  <= wr_dur;
    end
  end

  // Counter wrap detection, next tone level and per-note decode.
  always_comb begin
    half_wrap_s = (half_cnt_r == cur_half_r);
    tick_wrap_s = (tick_cnt_r == TICK_LAST);
    play_end_s  = tick_wrap_s && (tick_num_r == cur_last_r);
    if (GAP_ZERO) begin
      gap_end_s = 1'b1;
    end else begin
      gap_end_s = tick_wrap_s && (tick_num_r == GAP_LAST);
    end
    if (cur_half_r == {HALF_W{1'b0}}) begin
      tone_nxt_s = 1'b0;
    end else if (half_wrap_s) begin
      tone_nxt_s = ~tone_r;
    end else begin
      tone_nxt_s = tone_r;
    end
    last_note_s = (({1'b0, idx_r} + {{AW{1'b0}}, 1'b1}) == len_r);
    ld_dur_s    = dur_mem_r[idx_r];
    // A zero duration plays as one tick, so both encode a last-tick index of 0.
    if (ld_dur_s == {DUR_W{1'b0}}) begin
      ld_last_s = {NW{1'b0}};
    end else begin
      ld_last_s = NW'(ld_dur_s) - {{(NW-1){1'b0}}, 1'b1};
    end
    if (len > DEPTH_LEN) begin
      len_clamp_s = DEPTH_LEN;
    end else begin
      len_clamp_s = len;
    end
  end

`ifdef AUDIO_TONE_DECAY_EN
  logic [6:0] amp_r;
  logic [6:0] amp_nxt_s;

  // Envelope amplitude after this cycle's tick boundary, floored at zero.
  always_comb begin
    if (tick_wrap_s && (amp_r != 7'd0)) begin
      amp_nxt_s = amp_r - 7'd1;
    end else begin
      amp_nxt_s = amp_r;
    end
    level_s = amp_nxt_s;
  end

  // Envelope register: restarts at full level for each note, decays only while playing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp_r <= 7'd0;
    end else if (state_r == LOAD) begin
      amp_r <= DUTY_VAL;
    end else if (state_r == PLAY) begin
      amp_r <= amp_nxt_s;
    end else begin
      amp_r <= amp_r;
    end
  end
`else
  assign level_s = DUTY_VAL;
`endif

  // Sequencer FSM with all outputs registered; abort and reset return to a silent idle.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state_r    <= IDLE;
      idx_r      <= {AW{1'b0}};
      len_r      <= {(AW+1){1'b0}};
      cur_half_r <= {HALF_W{1'b0}};
      cur_last_r <= {NW{1'b0}};
      half_cnt_r <= {HALF_W{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
      tick_num_r <= {NW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tone_r     <= 1'b0;
      duty_r     <= 7'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (len == {(AW+1){1'b0}})) begin
            done_r <= 1'b1;
          end else if (start) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
            idx_r   <= {AW{1'b0}};
            len_r   <= len_clamp_s;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          cur_half_r <= half_mem_r[idx_r];
          cur_last_r <= ld_last_s;
          half_cnt_r <= {HALF_W{1'b0}};
          tick_cnt_r <= {TW{1'b0}};
          tick_num_r <= {NW{1'b0}};
          tone_r     <= 1'b0;
          duty_r     <= 7'd0;
          state_r    <= PLAY;
        end
        PLAY: begin
          if (tick_wrap_s) begin
            tick_cnt_r <= {TW{1'b0}};
          end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end
          if (play_end_s) begin
            state_r    <= GAP;
            tick_num_r <= {NW{1'b0}};
            half_cnt_r <= {HALF_W{1'b0}};
            tone_r     <= 1'b0;
            duty_r     <= 7'd0;
          end else begin
            if (tick_wrap_s) begin
              tick_num_r <= tick_num_r + NW'(1);
            end
            if (half_wrap_s) begin
              half_cnt_r <= {HALF_W{1'b0}};
            end else begin
              half_cnt_r <= half_cnt_r + HALF_W'(1);
            end
            tone_r <= tone_nxt_s;
            duty_r <= tone_nxt_s ? level_s : 7'd0;
          end
        end
        GAP: begin
          if (gap_end_s) begin
            tick_cnt_r <= {TW{1'b0}};
            tick_num_r <= {NW{1'b0}};
            if (last_note_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              idx_r   <= {AW{1'b0}};
            end else begin
              state_r <= LOAD;
              idx_r   <= idx_r + IDX_ONE;
            end
          end else begin
            if (tick_wrap_s) begin
              tick_cnt_r <= {TW{1'b0}};
              tick_num_r <= tick_num_r + NW'(1);
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          tone_r  <= 1'b0;
          duty_r  <= 7'd0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign tone_out   = tone_r;
  assign duty_cycle = duty_r;
  assign audio_en   = 1'b1;

endmodule

// File: doc/audio_tone_sequencer.md
AUDIO_TONE_SEQUENCER -- requirements
Module: audio_tone_sequencer

Interface
REQ-001 SHALL have parameter SYSTEM_FREQ, default 100000000, system clock in Hz (documentation only; no arithmetic on it).
REQ-002 SHALL have parameter TICK_CYCLES, default 100000, clk cycles per duration tick (1 ms at 100 MHz).
REQ-003 SHALL have parameter DEPTH, default 16, note-table entries (power of two, >=2); AW = log2(DEPTH).
REQ-004 SHALL have parameter HALF_W, default 20, width of half-period field.
REQ-005 SHALL have parameter DUR_W, default 12, width of duration field in ticks.
REQ-006 SHALL have parameter GAP_TICKS, default 10, silent ticks after each note.
REQ-007 SHALL have parameter DUTY_ON, default 100, 7-bit duty during tone high phase.
REQ-008 clk  input  1  system clock; all logic on rising edge.
REQ-009 rst_n  input  1  synchronous, active-low reset.
REQ-010 wr_en  input  1  write note-table entry.
REQ-011 wr_addr  input  AW  table address.
REQ-012 wr_half  input  HALF_W  clk cycles per half period minus 1; 0 = rest (silent note).
REQ-013 wr_dur  input  DUR_W  note length in ticks; 0 treated as 1.
REQ-014 start  input  1  one-cycle request to play entries 0..len-1.
REQ-015 len  input  AW+1  number of notes to play, sampled with start.
REQ-016 abort  input  1  stop playback immediately.
REQ-017 busy  output  1  sequence in progress.
REQ-018 done  output  1  one-cycle pulse on normal completion.
REQ-019 tone_out  output  1  square wave.
REQ-020 duty_cycle  output  7  duty for downstream PWMSerializer.
REQ-021 audio_en  output  1  constant 1.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, PLAY, GAP; IDLE->LOAD on start with len!=0; LOAD->PLAY after 1 cycle; PLAY->GAP when duration expires; GAP->LOAD (next index) or GAP->IDLE after final note.
REQ-023 start with len=0 in IDLE SHALL produce done=1 on the next cycle and no playback.
REQ-024 start while busy SHALL be ignored; writes SHALL be accepted only in IDLE and ignored otherwise.
REQ-025 busy SHALL be 1 in LOAD, PLAY, GAP and 0 in IDLE; busy rises the cycle after start.
REQ-026 LOAD SHALL register the entry at the current index; PLAY SHALL begin with tone_out=0 and half-period counter 0.
REQ-027 In PLAY with half!=0, tone_out SHALL toggle every half+1 cycles; with half=0, tone_out SHALL stay 0.
REQ-028 PLAY SHALL last exactly max(dur,1)*TICK_CYCLES cycles; GAP SHALL last exactly GAP_TICKS*TICK_CYCLES cycles (0 ticks = 1 cycle) with tone_out=0.
REQ-029 On final GAP expiry, the FSM SHALL enter IDLE with done=1 and busy=0 in the same cycle.
REQ-030 abort SHALL force IDLE on the next edge from any state: tone_out=0, duty_cycle=0, busy=0, no done; abort beats a simultaneous start.
REQ-031 duty_cycle SHALL equal DUTY_ON when tone_out=1, else 0 (unless REQ-037 applies).
REQ-032 Index SHALL count 0..len-1 with no wrap; len>DEPTH SHALL be clamped to DEPTH.

Reset
REQ-033 With rst_n=0 at a clk edge: state=IDLE, index=0, all counters=0, busy=0, done=0, tone_out=0, duty_cycle=0.
REQ-034 Reset SHALL NOT clear the note table; contents after power-up are undefined.
REQ-035 Reset mid-playback SHALL behave as abort but dominate all inputs that cycle.

Configuration
REQ-036 Macro AUDIO_TONE_DECAY_EN SHALL select envelope decay.
REQ-037 With AUDIO_TONE_DECAY_EN defined: an amplitude register SHALL load DUTY_ON on LOAD, decrement by 1 per tick in PLAY, saturate at 0; duty_cycle = tone_out ? amplitude : 0.
REQ-038 Without AUDIO_TONE_DECAY_EN: no amplitude register; REQ-031 holds.

Verification (TICK_CYCLES=10, GAP_TICKS=2 in bench)
REQ-039 Entry0 half=4,dur=3; start,len=1 -> busy next cycle; tone toggles every 5 cycles for 30 cycles; 20-cycle gap; done pulse; busy=0.
REQ-040 Entry0 half=0,dur=1 (rest) -> tone_out and duty_cycle held 0 for 10 cycles; done after gap.
REQ-041 start,len=0 -> done=1 next cycle, busy never asserted.
REQ-042 3-note sequence, abort during note 2 -> next cycle busy=0, tone_out=0, no done; later start replays from entry 0.
REQ-043 start and wr_en during PLAY -> both ignored; table entry unchanged.
REQ-044 AUDIO_TONE_DECAY_EN, half=1, dur=5 -> duty_cycle in high phases 100,99,98,97,96 per tick.
